counter_prog: RTL and testbench

//  Parametrised successor of the basic enable-gated counter: counts up or down toward a

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_prescaler.sv | 37 +++
 rtl/counter_prog.sv | 131 +++++++++++++
 tb/tb_counter_prog.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared encodings for the programmable counter
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_WRAP    = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - divides enabled run clocks into count ticks
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic w_unused;
            assign w_unused = clock_i ^ reset_i ^ clear_i;
            assign tick_o   = run_i;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] r_cnt;

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    r_cnt <= '0;
                end else if (clear_i) begin
                    r_cnt <= '0;
                end else if (run_i) begin
                    r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
                end
            end

            assign tick_o = run_i && (r_cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - up/down one-shot or wrapping counter with prescaler
module counter_prog
    import counter_pkg::*;
#(
    parameter int MAX_VALUE = 160,
    parameter int PRESCALE  = 1,
    localparam int W        = $clog2(MAX_VALUE + 1)
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         enable_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dir_i,
    input  logic         mode_i,
    output logic [W-1:0] counter_val_o,
    output logic         finished_o,
    output logic         wrap_o,
    output logic         busy_o
);

    localparam logic [W-1:0] MAXV = W'(MAX_VALUE);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         r_finished;
    logic         r_wrap;
    logic         r_busy;
    logic         w_finished_nxt;
    logic         w_wrap_nxt;
    logic         w_busy_nxt;

    logic         w_run;
    logic         w_tick;
    logic [W-1:0] w_start;
    logic [W-1:0] w_term;
    logic [W-1:0] w_load_val;
    logic         w_load_done;
    logic         w_at_term;
    logic [W-1:0] w_step;

    assign w_run       = enable_i && (r_state == ST_RUN);
    assign w_start     = (dir_i == DIR_DOWN) ? MAXV : '0;
    assign w_term      = (dir_i == DIR_DOWN) ? '0 : MAXV;
    assign w_load_val  = (load_val_i > MAXV) ? MAXV : load_val_i;
    assign w_load_done = (mode_i == MODE_ONESHOT) && (w_load_val == w_term);
    assign w_at_term   = (r_cnt == w_term);
    // Only used when not at terminal, so it never leaves 0..MAX_VALUE.
    assign w_step      = (dir_i == DIR_DOWN) ? r_cnt - W'(1) : r_cnt + W'(1);

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .run_i  (w_run),
        .clear_i(clear_i | load_i),
        .tick_o (w_tick)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else if (load_i) begin
            w_state_nxt = w_load_done ? ST_DONE : ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE: if (enable_i) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_tick && (mode_i == MODE_ONESHOT) &&
                        (w_at_term || (w_step == w_term))) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_nxt = 1'b0;
        if (clear_i) begin
            w_cnt_nxt = w_start;
        end else if (load_i) begin
            w_cnt_nxt = w_load_val;
        end else if ((r_state == ST_RUN) && w_tick) begin
            if (!w_at_term) begin
                w_cnt_nxt = w_step;
            end else if (mode_i == MODE_WRAP) begin
                w_cnt_nxt  = w_start;
                w_wrap_nxt = 1'b1;
            end
        end
        w_finished_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt     = (w_state_nxt == ST_RUN);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt      <= '0;
            r_finished <= 1'b0;
            r_wrap     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_finished <= w_finished_nxt;
            r_wrap     <= w_wrap_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign counter_val_o = r_cnt;
    assign finished_o    = r_finished;
    assign wrap_o        = r_wrap;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_counter_prog.sv
// tb/tb_counter_prog.sv - directed scoreboard bench for counter_prog
module tb_counter_prog;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear;
    logic       load;
    logic       dir;
    logic       mode;
    logic [2:0] load_val_a;
    logic [2:0] load_val_b;
    logic [7:0] load_val_c;

    logic [2:0] cnt_a, cnt_b;
    logic [7:0] cnt_c;
    logic       fin_a, fin_b, fin_c;
    logic       wrp_a, wrp_b, wrp_c;
    logic       bsy_a, bsy_b, bsy_c;

    counter_prog #(.MAX_VALUE(5), .PRESCALE(1)) dut_a (
        .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
        .load_i(load), .load_val_i(load_val_a), .dir_i(dir), .mode_i(mode),
        .counter_val_o(cnt_a), .finished_o(fin_a), .wrap_o(wrp_a), .busy_o(bsy_a)
    );

    counter_prog #(.MAX_VALUE(5), .PRESCALE(3)) dut_b (
        .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
        .load_i(load), .load_val_i(load_val_b), .dir_i(dir), .mode_i(mode),
        .counter_val_o(cnt_b), .finished_o(fin_b), .wrap_o(wrp_b), .busy_o(bsy_b)
    );

    counter_prog #(.MAX_VALUE(160), .PRESCALE(1)) dut_c (
        .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
        .load_i(load), .load_val_i(load_val_c), .dir_i(dir), .mode_i(mode),
        .counter_val_o(cnt_c), .finished_o(fin_c), .wrap_o(wrp_c), .busy_o(bsy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string tag;
        int    dut;
        int    cnt;
        logic  fin;
        logic  wrp;
        logic  bsy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input int d, input int c, input logic f, input logic w,
                        input logic b, input string tag);
        exp_t e;
        e.tag = tag; e.dut = d; e.cnt = c; e.fin = f; e.wrp = w; e.bsy = b;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        int   oc;
        logic of, ow, ob;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed 0 entries expected >=1");
            return;
        end
        e = sb.pop_front();
        case (e.dut)
            0:       begin oc = int'(cnt_a); of = fin_a; ow = wrp_a; ob = bsy_a; end
            1:       begin oc = int'(cnt_b); of = fin_b; ow = wrp_b; ob = bsy_b; end
            default: begin oc = int'(cnt_c); of = fin_c; ow = wrp_c; ob = bsy_c; end
        endcase
        checks++;
        assert (oc === e.cnt) else begin
            errors++;
            $error("FAIL %s.count observed %0d expected %0d", e.tag, oc, e.cnt);
        end
        checks++;
        assert (of === e.fin) else begin
            errors++;
            $error("FAIL %s.finished observed %b expected %b", e.tag, of, e.fin);
        end
        checks++;
        assert (ow === e.wrp) else begin
            errors++;
            $error("FAIL %s.wrap observed %b expected %b", e.tag, ow, e.wrp);
        end
        checks++;
        assert (ob === e.bsy) else begin
            errors++;
            $error("FAIL %s.busy observed %b expected %b", e.tag, ob, e.bsy);
        end
    endtask

    // One clock: expectation queued with the stimulus, compared on the falling edge.
    task automatic cyc(input int d, input int c, input logic f, input logic w,
                       input logic b, input string tag);
        push(d, c, f, w, b, tag);
        @(negedge clk);
        pop_cmp();
    endtask

    initial begin
        int   pc;
        int   ec;
        logic ew;
        logic en_now;

        rst = 1'b1; enable = 1'b1; clear = 1'b0; load = 1'b0;
        dir = 1'b0; mode = 1'b0;
        load_val_a = '0; load_val_b = '0; load_val_c = '0;

        // Test 1: reset, then one-shot up count.
        @(negedge clk); @(negedge clk);
        push(0, 0, 0, 0, 0, "reset_a"); pop_cmp();
        push(1, 0, 0, 0, 0, "reset_b"); pop_cmp();
        rst = 1'b0;
        cyc(0, 0, 0, 0, 1, "t1_idle_to_run");
        for (int i = 1; i <= 4; i++) cyc(0, i, 0, 0, 1, "t1_count");
        cyc(0, 5, 1, 0, 0, "t1_terminal");
        cyc(0, 5, 1, 0, 0, "t1_hold1");
        cyc(0, 5, 1, 0, 0, "t1_hold2");

        // Test 2: wrap mode with prescaler 3 and an enable gap.
        clear = 1'b1; mode = 1'b1; dir = 1'b0;
        cyc(1, 0, 0, 0, 0, "t2_clear");
        clear = 1'b0;
        cyc(1, 0, 0, 0, 1, "t2_start");
        pc = 0; ec = 0;
        for (int i = 0; i < 24; i++) begin
            en_now = !(i == 7 || i == 8);
            enable = en_now;
            ew = 1'b0;
            if (en_now) begin
                if (pc == 2) begin
                    pc = 0;
                    if (ec == 5) begin ec = 0; ew = 1'b1; end
                    else ec = ec + 1;
                end else begin
                    pc = pc + 1;
                end
            end
            cyc(1, ec, 0, ew, 1, "t2_prescale");
        end
        enable = 1'b1;

        // Test 3: down one-shot, then loads with clamping.
        dir = 1'b1; mode = 1'b0; clear = 1'b1;
        cyc(0, 5, 0, 0, 0, "t3_clear_down");
        clear = 1'b0;
        cyc(0, 5, 0, 0, 1, "t3_start");
        for (int i = 4; i >= 1; i--) cyc(0, i, 0, 0, 1, "t3_count");
        cyc(0, 0, 1, 0, 0, "t3_terminal");
        cyc(0, 0, 1, 0, 0, "t3_hold");
        load = 1'b1; load_val_a = 3'd7;
        cyc(0, 5, 0, 0, 1, "t3_load_clamp");
        load = 1'b0;
        cyc(0, 4, 0, 0, 1, "t3_after_load");
        load = 1'b1; dir = 1'b0;
        cyc(0, 5, 1, 0, 0, "t3_load_terminal");
        load = 1'b0;
        cyc(0, 5, 1, 0, 0, "t3_done_hold");

        // Test 4: clear beats load.
        clear = 1'b1;
        cyc(0, 0, 0, 0, 0, "t4_clear");
        clear = 1'b0;
        cyc(0, 0, 0, 0, 1, "t4_run");
        cyc(0, 1, 0, 0, 1, "t4_count");
        clear = 1'b1; load = 1'b1; load_val_a = 3'd3;
        cyc(0, 0, 0, 0, 0, "t4_clear_wins");
        clear = 1'b0; load = 1'b0;

        // Test 5: asynchronous reset between edges.
        cyc(0, 0, 0, 0, 1, "t5_run");
        for (int i = 1; i <= 3; i++) cyc(0, i, 0, 0, 1, "t5_count");
        #2 rst = 1'b1;
        push(0, 0, 0, 0, 0, "t5_async_a");
        push(1, 0, 0, 0, 0, "t5_async_b");
        push(2, 0, 0, 0, 0, "t5_async_c");
        #1;
        pop_cmp(); pop_cmp(); pop_cmp();
        @(negedge clk);
        rst = 1'b0;

        // Test 6: 160-wide wrap.
        dir = 1'b0; mode = 1'b1; enable = 1'b1;
        cyc(2, 0, 0, 0, 1, "t6_start");
        for (int i = 1; i <= 160; i++) cyc(2, i, 0, 0, 1, "t6_count");
        cyc(2, 0, 0, 1, 1, "t6_wrap");
        cyc(2, 1, 0, 0, 1, "t6_after_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
